// File: rtl/riscv_configs.sv
// riscv_configs: core-wide defaults shared by fetch, decode and the hazard unit
package riscv_configs;
    localparam int          DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    localparam int          DEF_CNT_W     = 32;
endpackage

// File: rtl/riscv_pipe_reg.sv
// riscv_pipe_reg: pipeline register with sync reset, clear and enable (rst > clr > en)
module riscv_pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    always_ff @(posedge i_clk)
        if (i_rst) o_q <= RST_VAL;
        else if (i_clr) o_q <= CLR_VAL;
        else if (i_en) o_q <= i_d;
endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC, next-PC select, IF/ID register and stall/flush counters
module riscv_fetch_stage
    import riscv_configs::*;
#(
    parameter int               XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEF_RESET_PC),
    parameter logic [31:0]      NOP_INSTR = DEF_NOP_INSTR,
    parameter int               CNT_W     = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall_f,
    input  logic             i_stall_d,
    input  logic             i_flush_d,
    input  logic             i_pc_src_e,
    input  logic [XLEN-1:0]  i_pc_target_e,
    output logic [XLEN-1:0]  o_imem_addr,
    input  logic [31:0]      i_imem_rdata,
    output logic [XLEN-1:0]  o_pc_f,
    output logic [31:0]      o_instr_d,
    output logic [XLEN-1:0]  o_pc_d,
    output logic [XLEN-1:0]  o_pc_plus4_d,
    output logic             o_valid_d,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    localparam int            IW     = 32 + 2 * XLEN + 1;
    localparam logic [IW-1:0] BUBBLE = {NOP_INSTR, {(2 * XLEN){1'b0}}, 1'b0};

    logic [XLEN-1:0] pc_plus4_f, pc_next;

    assign pc_plus4_f  = o_pc_f + XLEN'(4);
    // no compressed instructions, so the target is forced word-aligned
    assign pc_next     = i_pc_src_e ? {i_pc_target_e[XLEN-1:2], 2'b00} : pc_plus4_f;
    assign o_imem_addr = o_pc_f;

    // redirect overrides a stall so a taken branch is never dropped
    riscv_pipe_reg #(.WIDTH(XLEN), .RST_VAL(RESET_PC), .CLR_VAL('0)) u_pc_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (1'b0),
        .i_en  (~i_stall_f | i_pc_src_e),
        .i_d   (pc_next),
        .o_q   (o_pc_f)
    );

    riscv_pipe_reg #(.WIDTH(IW), .RST_VAL(BUBBLE), .CLR_VAL(BUBBLE)) u_ifid_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush_d),
        .i_en  (~i_stall_d),
        .i_d   ({i_imem_rdata, o_pc_f, pc_plus4_f, 1'b1}),
        .o_q   ({o_instr_d, o_pc_d, o_pc_plus4_d, o_valid_d})
    );

    always_ff @(posedge i_clk) begin
        o_stall_cnt <= i_rst ? '0 : o_stall_cnt + CNT_W'(i_stall_f);
        o_flush_cnt <= i_rst ? '0 : o_flush_cnt + CNT_W'(i_flush_d);
    end
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: directed checks of fetch stage, with a second instance for PC wrap
module tb_riscv_fetch_stage;
    logic        clk = 0;
    logic        rst, stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus4_d, stall_cnt, flush_cnt;
    logic        valid_d;
    logic [31:0] w_imem_addr, w_imem_rdata, w_pc_f, w_instr_d, w_pc_d, w_pc_plus4_d, w_stall_cnt, w_flush_cnt;
    logic        w_valid_d;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00a0_0113 : {a[23:0], 8'h13};
    endfunction

    assign imem_rdata   = mem(imem_addr);
    assign w_imem_rdata = mem(w_imem_addr);

    riscv_fetch_stage dut (
        .i_clk(clk), .i_rst(rst), .i_stall_f(stall_f), .i_stall_d(stall_d),
        .i_flush_d(flush_d), .i_pc_src_e(pc_src_e), .i_pc_target_e(pc_target_e),
        .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata), .o_pc_f(pc_f),
        .o_instr_d(instr_d), .o_pc_d(pc_d), .o_pc_plus4_d(pc_plus4_d), .o_valid_d(valid_d),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    riscv_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_stall_f(stall_f), .i_stall_d(stall_d),
        .i_flush_d(flush_d), .i_pc_src_e(pc_src_e), .i_pc_target_e(pc_target_e),
        .o_imem_addr(w_imem_addr), .i_imem_rdata(w_imem_rdata), .o_pc_f(w_pc_f),
        .o_instr_d(w_instr_d), .o_pc_d(w_pc_d), .o_pc_plus4_d(w_pc_plus4_d), .o_valid_d(w_valid_d),
        .o_stall_cnt(w_stall_cnt), .o_flush_cnt(w_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [31:0] pf, input logic [31:0] ins,
                           input logic [31:0] pd, input logic v);
        check({tag, ".pc_f"}, pc_f, pf);
        check({tag, ".imem_addr"}, imem_addr, pf);
        check({tag, ".instr_d"}, instr_d, ins);
        check({tag, ".pc_d"}, pc_d, pd);
        check({tag, ".pc_plus4_d"}, pc_plus4_d, v ? pd + 32'd4 : 32'd0);
        check({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, v});
    endtask

    initial begin
        rst = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
        step(); step();
        check_d("reset", 32'h0, 32'h13, 32'h0, 1'b0);
        check("reset.stall_cnt", stall_cnt, 32'd0);
        check("reset.flush_cnt", flush_cnt, 32'd0);
        check("wrap.reset_pc", w_pc_f, 32'hFFFF_FFFC);
        rst = 0;
        step();
        check_d("run1", 32'h4, 32'h0050_0093, 32'h0, 1'b1);
        check("wrap.pc_f", w_pc_f, 32'h0);
        check("wrap.pc_d", w_pc_d, 32'hFFFF_FFFC);
        check("wrap.pc_plus4_d", w_pc_plus4_d, 32'h0);
        step();
        check_d("run2", 32'h8, 32'h00a0_0113, 32'h4, 1'b1);
        stall_f = 1; stall_d = 1;
        step();
        check_d("stall", 32'h8, 32'h00a0_0113, 32'h4, 1'b1);
        check("stall.stall_cnt", stall_cnt, 32'd1);
        stall_f = 0; stall_d = 0;
        step();
        check_d("post_stall", 32'hC, 32'h0000_0813, 32'h8, 1'b1);
        step();
        check_d("run3", 32'h10, 32'h0000_0C13, 32'hC, 1'b1);
        pc_src_e = 1; flush_d = 1; pc_target_e = 32'h40;
        step();
        check_d("redirect", 32'h40, 32'h13, 32'h0, 1'b0);
        check("redirect.flush_cnt", flush_cnt, 32'd1);
        pc_src_e = 0; flush_d = 0;
        step();
        check_d("target", 32'h44, 32'h0000_4013, 32'h40, 1'b1);
        stall_f = 1; stall_d = 1; pc_src_e = 1; flush_d = 1; pc_target_e = 32'h83;
        step();
        check_d("redir_stall", 32'h80, 32'h13, 32'h0, 1'b0);
        check("redir_stall.stall_cnt", stall_cnt, 32'd2);
        check("redir_stall.flush_cnt", flush_cnt, 32'd2);
        stall_f = 0; stall_d = 0; pc_src_e = 0; flush_d = 0;
        step();
        check_d("after_redir", 32'h84, 32'h0000_8013, 32'h80, 1'b1);
        stall_f = 1; stall_d = 1; rst = 1; pc_src_e = 1; pc_target_e = 32'h200;
        step();
        check_d("rst_in_stall", 32'h0, 32'h13, 32'h0, 1'b0);
        check("rst_in_stall.stall_cnt", stall_cnt, 32'd0);
        check("rst_in_stall.flush_cnt", flush_cnt, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
